// File: rtl/usb_transaction_controller.sv
// usb_transaction_controller: device-side USB full-speed SETUP/OUT/IN transaction sequencer
module usb_transaction_controller #(
    parameter int ENDPOINT_COUNT = 4,
    parameter int IPD_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 72
) (
    input  logic                      clock48,
    input  logic                      reset,
    input  logic                      bus_reset,
    input  logic [6:0]                device_address,
    input  logic                      rx_token_valid,
    input  logic [3:0]                rx_pid,
    input  logic [6:0]                rx_address,
    input  logic [3:0]                rx_endpoint,
    input  logic                      rx_data_valid,
    input  logic                      rx_crc_ok,
    output logic                      tx_start,
    output logic [3:0]                tx_pid,
    output logic [3:0]                tx_endpoint,
    input  logic                      tx_done,
    input  logic [ENDPOINT_COUNT-1:0] ep_out_ready,
    input  logic [ENDPOINT_COUNT-1:0] ep_in_ready,
    input  logic [ENDPOINT_COUNT-1:0] ep_stall,
    output logic                      out_commit,
    output logic                      out_discard,
    output logic                      setup_received,
    output logic                      in_commit,
    output logic [3:0]                xfer_endpoint
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IPD_LOAD = TW'(IPD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, DELAY, SEND, WAIT_TX, WAIT_ACK} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    ep, ep_n;
    logic          is_setup, is_setup_n;
    logic [15:0]   toggle, toggle_n;
    logic [3:0]    tx_pid_n, tx_endpoint_n, xfer_endpoint_n;
    logic          out_commit_n, out_discard_n, setup_received_n, in_commit_n;
    logic [15:0]   stall_x, in_rdy_x, out_rdy_x;
    logic          tok_ok;

    // endpoint vectors widened to the full 4-bit endpoint space so any endpoint number indexes safely
    assign stall_x   = 16'(ep_stall);
    assign in_rdy_x  = 16'(ep_in_ready);
    assign out_rdy_x = 16'(ep_out_ready);
    assign tok_ok    = rx_token_valid && rx_address == device_address &&
                       {1'b0, rx_endpoint} < 5'(ENDPOINT_COUNT) &&
                       (rx_pid == PID_SETUP || rx_pid == PID_OUT || rx_pid == PID_IN);

    // state register and registered datapath/outputs
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            ep             <= '0;
            is_setup       <= 1'b0;
            toggle         <= '0;
            tx_pid         <= '0;
            tx_endpoint    <= '0;
            xfer_endpoint  <= '0;
            out_commit     <= 1'b0;
            out_discard    <= 1'b0;
            setup_received <= 1'b0;
            in_commit      <= 1'b0;
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            ep             <= ep_n;
            is_setup       <= is_setup_n;
            toggle         <= toggle_n;
            tx_pid         <= tx_pid_n;
            tx_endpoint    <= tx_endpoint_n;
            xfer_endpoint  <= xfer_endpoint_n;
            out_commit     <= out_commit_n;
            out_discard    <= out_discard_n;
            setup_received <= setup_received_n;
            in_commit      <= in_commit_n;
        end
    end

    // next-state: transaction decode, response choice, toggle bookkeeping and timers
    always_comb begin
        state_n          = state;
        timer_n          = timer;
        ep_n             = ep;
        is_setup_n       = is_setup;
        toggle_n         = toggle;
        tx_pid_n         = tx_pid;
        tx_endpoint_n    = tx_endpoint;
        xfer_endpoint_n  = xfer_endpoint;
        out_commit_n     = 1'b0;
        out_discard_n    = 1'b0;
        setup_received_n = 1'b0;
        in_commit_n      = 1'b0;
        case (state)
            IDLE, WAIT_DATA: begin
                if (state == WAIT_DATA) begin
                    if (rx_token_valid) begin
                        out_discard_n   = 1'b1;
                        xfer_endpoint_n = ep;
                        state_n         = IDLE;
                    end else if (rx_data_valid) begin
                        xfer_endpoint_n = ep;
                        tx_endpoint_n   = ep;
                        timer_n         = IPD_LOAD;
                        state_n         = DELAY;
                        if (!rx_crc_ok) begin
                            out_discard_n = 1'b1;
                            state_n       = IDLE;
                        end else if (is_setup) begin
                            if (rx_pid == PID_DATA0) begin
                                out_commit_n     = 1'b1;
                                setup_received_n = 1'b1;
                                toggle_n[ep]     = 1'b1;
                                tx_pid_n         = PID_ACK;
                            end else begin
                                out_discard_n = 1'b1;
                                state_n       = IDLE;
                            end
                        end else if (stall_x[ep]) begin
                            tx_pid_n      = PID_STALL;
                            out_discard_n = 1'b1;
                        end else if (!out_rdy_x[ep]) begin
                            tx_pid_n      = PID_NAK;
                            out_discard_n = 1'b1;
                        end else if (rx_pid[3] != toggle[ep]) begin
                            tx_pid_n      = PID_ACK;
                            out_discard_n = 1'b1;
                        end else begin
                            tx_pid_n     = PID_ACK;
                            out_commit_n = 1'b1;
                            toggle_n[ep] = ~toggle[ep];
                        end
                    end else if (timer == '0) begin
                        out_discard_n   = 1'b1;
                        xfer_endpoint_n = ep;
                        state_n         = IDLE;
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                if (tok_ok) begin
                    ep_n          = rx_endpoint;
                    is_setup_n    = rx_pid == PID_SETUP;
                    tx_endpoint_n = rx_endpoint;
                    if (rx_pid == PID_IN) begin
                        tx_pid_n = stall_x[rx_endpoint] ? PID_STALL :
                                   !in_rdy_x[rx_endpoint] ? PID_NAK :
                                   toggle[rx_endpoint] ? PID_DATA1 : PID_DATA0;
                        timer_n  = IPD_LOAD;
                        state_n  = DELAY;
                    end else begin
                        timer_n = TO_LOAD;
                        state_n = WAIT_DATA;
                    end
                end
            end
            DELAY: begin
                state_n = timer == '0 ? SEND : DELAY;
                timer_n = timer == '0 ? timer : timer - 1'b1;
            end
            SEND: state_n = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    state_n = (tx_pid == PID_DATA0 || tx_pid == PID_DATA1) ? WAIT_ACK : IDLE;
                    timer_n = TO_LOAD;
                end
            end
            WAIT_ACK: begin
                if (rx_token_valid) begin
                    state_n = IDLE;
                    if (rx_pid == PID_ACK) begin
                        in_commit_n     = 1'b1;
                        xfer_endpoint_n = ep;
                        toggle_n[ep]    = ~toggle[ep];
                    end
                end else if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus_reset) begin
            state_n          = IDLE;
            timer_n          = '0;
            ep_n             = '0;
            is_setup_n       = 1'b0;
            toggle_n         = '0;
            tx_pid_n         = '0;
            tx_endpoint_n    = '0;
            xfer_endpoint_n  = '0;
            out_commit_n     = 1'b0;
            out_discard_n    = 1'b0;
            setup_received_n = 1'b0;
            in_commit_n      = 1'b0;
        end
    end

    // transmit strobe; a bus reset in the SEND cycle suppresses it
    always_comb tx_start = state == SEND && !bus_reset;
endmodule

// File: tb/tb_usb_transaction_controller.sv
// tb_usb_transaction_controller: directed vector table plus timing and bus-reset sequences
module tb_usb_transaction_controller;
    localparam int IPD = 8;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
    localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011;
    localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;

    typedef struct {
        string      name;
        logic [3:0] tok;
        logic [6:0] addr;
        logic [3:0] ep;
        bit         has_data;
        logic [3:0] dpid;
        bit         crc;
        bit         ack;
        logic [3:0] stall;
        logic [3:0] in_rdy;
        logic [3:0] out_rdy;
        int         e_tx;
        logic [3:0] e_pid;
        int         e_commit;
        int         e_discard;
        int         e_setup;
        int         e_inc;
    } vec_t;

    logic clock48 = 1'b0, reset = 1'b1, bus_reset = 1'b0;
    logic [6:0] device_address = 7'd1;
    logic rx_token_valid = 1'b0, rx_data_valid = 1'b0, rx_crc_ok = 1'b0;
    logic [3:0] rx_pid = '0, rx_endpoint = '0;
    logic [6:0] rx_address = '0;
    logic tx_start, tx_done = 1'b0;
    logic [3:0] tx_pid, tx_endpoint, xfer_endpoint;
    logic [3:0] ep_out_ready = '0, ep_in_ready = '0, ep_stall = '0;
    logic out_commit, out_discard, setup_received, in_commit;

    int tests = 0, fails = 0, cyc = 0;
    int n_tx = 0, n_commit = 0, n_discard = 0, n_setup = 0, n_inc = 0, tx_cyc = 0, commit_cyc = 0;
    logic [3:0] last_pid = '0, last_ep = '0, last_xfer = '0;
    vec_t vecs[18];

    usb_transaction_controller #(.ENDPOINT_COUNT(4), .IPD_CYCLES(IPD), .TIMEOUT_CYCLES(72)) dut (
        .clock48(clock48), .reset(reset), .bus_reset(bus_reset), .device_address(device_address),
        .rx_token_valid(rx_token_valid), .rx_pid(rx_pid), .rx_address(rx_address),
        .rx_endpoint(rx_endpoint), .rx_data_valid(rx_data_valid), .rx_crc_ok(rx_crc_ok),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_endpoint(tx_endpoint), .tx_done(tx_done),
        .ep_out_ready(ep_out_ready), .ep_in_ready(ep_in_ready), .ep_stall(ep_stall),
        .out_commit(out_commit), .out_discard(out_discard), .setup_received(setup_received),
        .in_commit(in_commit), .xfer_endpoint(xfer_endpoint)
    );

    always #10 clock48 = ~clock48;

    always @(posedge clock48) cyc <= cyc + 1;

    // event monitor sampling on the falling edge
    always @(negedge clock48) begin
        if (tx_start) begin
            n_tx++;
            last_pid = tx_pid;
            last_ep  = tx_endpoint;
            tx_cyc   = cyc;
        end
        if (out_commit) begin
            n_commit++;
            commit_cyc = cyc;
        end
        if (out_discard) n_discard++;
        if (setup_received) n_setup++;
        if (in_commit) n_inc++;
        if (out_commit || out_discard || in_commit) last_xfer = xfer_endpoint;
    end

    // transmitter model: finishes each packet a few cycles after tx_start
    always begin
        @(negedge clock48);
        if (tx_start) begin
            repeat (4) @(posedge clock48);
            #2 tx_done = 1'b1;
            @(posedge clock48);
            #2 tx_done = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic token(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e);
        @(posedge clock48);
        #2 rx_token_valid = 1'b1;
        rx_pid = pid;
        rx_address = a;
        rx_endpoint = e;
        @(posedge clock48);
        #2 rx_token_valid = 1'b0;
    endtask

    task automatic data(input logic [3:0] pid, input bit crc);
        @(posedge clock48);
        #2 rx_data_valid = 1'b1;
        rx_pid = pid;
        rx_crc_ok = crc;
        @(posedge clock48);
        #2 rx_data_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int s_tx, s_c, s_d, s_s, s_i;
        ep_stall = v.stall;
        ep_in_ready = v.in_rdy;
        ep_out_ready = v.out_rdy;
        s_tx = n_tx; s_c = n_commit; s_d = n_discard; s_s = n_setup; s_i = n_inc;
        token(v.tok, v.addr, v.ep);
        if (v.has_data) begin
            repeat (2) @(posedge clock48);
            data(v.dpid, v.crc);
        end
        repeat (25) @(posedge clock48);
        if (v.ack) token(P_ACK, 7'd0, 4'd0);
        repeat (80) @(posedge clock48);
        @(negedge clock48);
        check({v.name, " tx_count"}, n_tx - s_tx, v.e_tx);
        if (v.e_tx != 0) check({v.name, " tx_pid"}, {28'd0, last_pid}, {28'd0, v.e_pid});
        if (v.e_tx != 0 && v.tok == P_IN) check({v.name, " tx_endpoint"}, {28'd0, last_ep}, {28'd0, v.ep});
        check({v.name, " out_commit"}, n_commit - s_c, v.e_commit);
        check({v.name, " out_discard"}, n_discard - s_d, v.e_discard);
        check({v.name, " setup_received"}, n_setup - s_s, v.e_setup);
        check({v.name, " in_commit"}, n_inc - s_i, v.e_inc);
        if (v.e_commit + v.e_discard + v.e_inc != 0)
            check({v.name, " xfer_endpoint"}, {28'd0, last_xfer}, {28'd0, v.ep});
    endtask

    initial begin
        int t0, s_tx, s_s;
        vec_t vb;
        //          name              tok      addr   ep    dat  dpid  crc  ack  stall   in_rdy  out_rdy tx pid     c  d  s  i
        vecs[0]  = '{"setup_ep0",     P_SETUP, 7'd1, 4'd0, 1'b1, P_D0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1, P_ACK,   1, 0, 1, 0};
        vecs[1]  = '{"out_ep0_new",   P_OUT,   7'd1, 4'd0, 1'b1, P_D1, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1, P_ACK,   1, 0, 0, 0};
        vecs[2]  = '{"out_ep0_retry", P_OUT,   7'd1, 4'd0, 1'b1, P_D1, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1, P_ACK,   0, 1, 0, 0};
        vecs[3]  = '{"setup_ep0_b",   P_SETUP, 7'd1, 4'd0, 1'b1, P_D0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1, P_ACK,   1, 0, 1, 0};
        vecs[4]  = '{"in_ep0_d1_ack", P_IN,    7'd1, 4'd0, 1'b0, P_D0, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1, P_D1,    0, 0, 0, 1};
        vecs[5]  = '{"in_ep0_noack",  P_IN,    7'd1, 4'd0, 1'b0, P_D0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1, P_D0,    0, 0, 0, 0};
        vecs[6]  = '{"in_ep0_resend", P_IN,    7'd1, 4'd0, 1'b0, P_D0, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1, P_D0,    0, 0, 0, 1};
        vecs[7]  = '{"in_ep1_stall",  P_IN,    7'd1, 4'd1, 1'b0, P_D0, 1'b0, 1'b0, 4'h2, 4'hF, 4'hF, 1, P_STALL, 0, 0, 0, 0};
        vecs[8]  = '{"in_ep1_nak",    P_IN,    7'd1, 4'd1, 1'b0, P_D0, 1'b0, 1'b0, 4'h0, 4'hD, 4'hF, 1, P_NAK,   0, 0, 0, 0};
        vecs[9]  = '{"in_addr2",      P_IN,    7'd2, 4'd0, 1'b0, P_D0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 0, 4'h0,    0, 0, 0, 0};
        vecs[10] = '{"in_ep5",        P_IN,    7'd1, 4'd5, 1'b0, P_D0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 0, 4'h0,    0, 0, 0, 0};
        vecs[11] = '{"out_badcrc",    P_OUT,   7'd1, 4'd0, 1'b1, P_D0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 0, 4'h0,    0, 1, 0, 0};
        vecs[12] = '{"out_timeout",   P_OUT,   7'd1, 4'd0, 1'b0, P_D0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 0, 4'h0,    0, 1, 0, 0};
        vecs[13] = '{"out_ep1_stall", P_OUT,   7'd1, 4'd1, 1'b1, P_D0, 1'b1, 1'b0, 4'h2, 4'hF, 4'hF, 1, P_STALL, 0, 1, 0, 0};
        vecs[14] = '{"out_ep1_nak",   P_OUT,   7'd1, 4'd1, 1'b1, P_D0, 1'b1, 1'b0, 4'h0, 4'hF, 4'hD, 1, P_NAK,   0, 1, 0, 0};
        vecs[15] = '{"setup_ep1_d1",  P_SETUP, 7'd1, 4'd1, 1'b1, P_D1, 1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 0, 4'h0,    0, 1, 0, 0};
        vecs[16] = '{"setup_ep1_stl", P_SETUP, 7'd1, 4'd1, 1'b1, P_D0, 1'b1, 1'b0, 4'h2, 4'hF, 4'hF, 1, P_ACK,   1, 0, 1, 0};
        vecs[17] = '{"in_ep1_d1_ack", P_IN,    7'd1, 4'd1, 1'b0, P_D0, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1, P_D1,    0, 0, 0, 1};

        repeat (3) @(posedge clock48);
        @(negedge clock48);
        check("reset tx_start", {31'd0, tx_start}, 32'd0);
        check("reset tx_pid", {28'd0, tx_pid}, 32'd0);
        check("reset tx_endpoint", {28'd0, tx_endpoint}, 32'd0);
        check("reset xfer_endpoint", {28'd0, xfer_endpoint}, 32'd0);
        check("reset pulses", {28'd0, out_commit, out_discard, setup_received, in_commit}, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clock48);
        @(negedge clock48);
        check("idle no tx", n_tx, 0);

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        ep_stall = 4'h0;
        ep_out_ready = 4'hF;
        s_tx = n_tx;
        s_s = n_setup;
        token(P_SETUP, 7'd1, 4'd0);
        @(posedge clock48);
        #2 rx_data_valid = 1'b1;
        rx_pid = P_D0;
        rx_crc_ok = 1'b1;
        t0 = cyc;
        @(posedge clock48);
        #2 rx_data_valid = 1'b0;
        repeat (30) @(posedge clock48);
        @(negedge clock48);
        check("latency tx_count", n_tx - s_tx, 1);
        check("latency tx_start", tx_cyc - t0, IPD + 1);
        check("latency commit", commit_cyc - t0, 1);
        check("latency pid", {28'd0, last_pid}, {28'd0, P_ACK});
        check("latency setup", n_setup - s_s, 1);

        run_vec(vecs[16]);
        ep_stall = 4'h0;
        ep_in_ready = 4'hF;
        s_tx = n_tx;
        token(P_IN, 7'd1, 4'd0);
        repeat (3) @(posedge clock48);
        #2 bus_reset = 1'b1;
        @(posedge clock48);
        @(negedge clock48);
        check("busrst tx_start", {31'd0, tx_start}, 32'd0);
        check("busrst tx_pid", {28'd0, tx_pid}, 32'd0);
        check("busrst pulses", {28'd0, out_commit, out_discard, setup_received, in_commit}, 32'd0);
        bus_reset = 1'b0;
        repeat (30) @(posedge clock48);
        @(negedge clock48);
        check("busrst no tx", n_tx - s_tx, 0);
        vb = '{"busrst_in_ep0", P_IN, 7'd1, 4'd0, 1'b0, P_D0, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1, P_D0, 0, 0, 0, 1};
        run_vec(vb);
        vb = '{"busrst_in_ep1", P_IN, 7'd1, 4'd1, 1'b0, P_D0, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1, P_D0, 0, 0, 0, 1};
        run_vec(vb);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
